// File: rtl/cmd_sched_if.sv
// Command handshake bundle between the UART front end, the scheduler queue and cmd_proc.
// master drives commands and pop/flush strobes; slave is the scheduler.
interface cmd_sched_if #(parameter int DEPTH = 4);
    logic [15:0]            cmd_in;
    logic                   cmd_in_rdy;
    logic                   clr_in_rdy;
    logic [15:0]            cmd_out;
    logic                   cmd_out_rdy;
    logic                   cap_cmd;
    logic                   flush;
    logic [$clog2(DEPTH):0] count;
    logic                   full;
    logic                   stall;
    logic [7:0]             accepted;

    modport master (
        output cmd_in, cmd_in_rdy, cap_cmd, flush,
        input  clr_in_rdy, cmd_out, cmd_out_rdy, count, full, stall, accepted
    );

    modport slave (
        input  cmd_in, cmd_in_rdy, cap_cmd, flush,
        output clr_in_rdy, cmd_out, cmd_out_rdy, count, full, stall, accepted
    );
endinterface

// File: rtl/cmd_sched.sv
// Command scheduler: buffers UART command words in a circular queue for cmd_proc.
//   state | meaning
//   WAIT  | idle, accept cmd_in when room (or a same-cycle pop frees a slot)
//   ACK   | pulse clr_in_rdy for one cycle while UART cmd_rdy falls; no write
module cmd_sched #(
    parameter int DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    cmd_sched_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {WAIT, ACK} state_t;

    state_t        state;
    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [7:0]    acc;
    logic          full_w;
    logic          push;
    logic          pop;

    assign full_w = (cnt == CW'(DEPTH));
    assign pop    = bus.cap_cmd && (cnt != '0) && !bus.flush;
    assign push   = (state == WAIT) && bus.cmd_in_rdy && (!full_w || bus.cap_cmd) && !bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= WAIT;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            acc    <= '0;
        end else if (bus.flush) begin
            state  <= WAIT;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                WAIT:    if (push) state <= ACK;
                default: state <= WAIT;
            endcase
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                acc    <= acc + 8'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                cnt <= cnt + CW'(1);
            else if (pop && !push)
                cnt <= cnt - CW'(1);
        end
    end

    // Storage is deliberately left unreset; cmd_out is only meaningful with cmd_out_rdy.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.cmd_in;
    end

    // A flush landing in ACK cancels the acknowledge so UART keeps its word pending.
    assign bus.clr_in_rdy  = (state == ACK) && !bus.flush;
    assign bus.cmd_out     = mem[rd_ptr];
    assign bus.cmd_out_rdy = (cnt != '0);
    assign bus.count       = cnt;
    assign bus.full        = full_w;
    assign bus.stall       = bus.cmd_in_rdy && full_w && !bus.cap_cmd;
    assign bus.accepted    = acc;
endmodule

// File: tb/tb_cmd_sched.sv
// Self-checking bench for cmd_sched: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_cmd_sched;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    cmd_sched_if #(.DEPTH(DEPTH)) bus ();

    cmd_sched #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] q[$];
    int          m_acc  = 0;
    bit          m_ack  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_acc = 0;
        m_ack = 0;
    endtask

    // One clock cycle, entered and left at a negedge.
    task automatic step(input logic rdy, input logic [15:0] data, input logic cap,
                        input logic fl, output logic clr_o);
        bit do_push;
        bit do_pop;
        check_val("count", 32'(bus.count), 32'(q.size()));
        check_val("cmd_out_rdy", 32'(bus.cmd_out_rdy), 32'(q.size() != 0));
        check_val("full", 32'(bus.full), 32'(q.size() == DEPTH));
        check_val("accepted", 32'(bus.accepted), 32'(m_acc));
        if (q.size() != 0)
            check_val("cmd_out", 32'(bus.cmd_out), 32'(q[0]));
        bus.cmd_in_rdy = rdy;
        bus.cmd_in     = data;
        bus.cap_cmd    = cap;
        bus.flush      = fl;
        #1;
        check_val("clr_in_rdy", 32'(bus.clr_in_rdy), 32'(m_ack && !fl));
        check_val("stall", 32'(bus.stall), 32'(rdy && q.size() == DEPTH && !cap));
        clr_o   = bus.clr_in_rdy;
        do_push = !fl && rdy && !m_ack && (q.size() < DEPTH || cap);
        do_pop  = !fl && cap && q.size() != 0;
        @(posedge clk);
        if (fl) begin
            q.delete();
            m_ack = 0;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back(data);
                m_acc = (m_acc + 1) % 256;
            end
            m_ack = do_push;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.cmd_in_rdy = 1'b0;
        bus.cmd_in     = '0;
        bus.cap_cmd    = 1'b0;
        bus.flush      = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    // Present a word for its accept cycle plus the acknowledge cycle.
    task automatic push_word(input logic [15:0] w);
        logic c;
        step(1'b1, w, 1'b0, 1'b0, c);
        step(1'b1, w, 1'b0, 1'b0, c);
    endtask

    initial begin
        logic        c;
        logic        up_valid;
        logic [15:0] up_data;
        logic        saw_clr;
        int          cap_pct;

        do_reset();

        // single word right after reset
        step(1'b1, 16'h00A7, 1'b0, 1'b0, c);
        step(1'b1, 16'h00A7, 1'b0, 1'b0, c);
        check_val("single_clr", 32'(c), 32'd1);
        check_val("single_out", 32'(bus.cmd_out), 32'h00A7);
        check_val("single_cnt", 32'(bus.count), 32'd1);
        check_val("single_acc", 32'(bus.accepted), 32'd1);

        // fill then stall, then push+pop at full
        do_reset();
        for (int i = 1; i <= 4; i++) push_word(16'(i));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'h0005, 1'b0, 1'b0, c);
            check_val("stall_noclr", 32'(c), 32'd0);
        end
        check_val("stall_full", 32'(bus.full), 32'd1);
        step(1'b1, 16'h0005, 1'b1, 1'b0, c);
        check_val("pp_cnt", 32'(bus.count), 32'd4);
        check_val("pp_out", 32'(bus.cmd_out), 32'h0002);
        step(1'b0, 16'h0000, 1'b0, 1'b0, c);

        // drain in order, then an extra pop on empty
        for (int i = 2; i <= 5; i++) begin
            check_val("drain_out", 32'(bus.cmd_out), 32'(i));
            step(1'b0, 16'h0000, 1'b1, 1'b0, c);
        end
        check_val("drain_cnt", 32'(bus.count), 32'd0);
        check_val("drain_rdy", 32'(bus.cmd_out_rdy), 32'd0);
        step(1'b0, 16'h0000, 1'b1, 1'b0, c);
        check_val("empty_pop", 32'(bus.count), 32'd0);

        // wrap-around with push/pop pairs
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, c);
            check_val("wrap_out", 32'(bus.cmd_out), 32'h0100 + 32'(i));
            step(1'b0, 16'h0000, 1'b1, 1'b0, c);
        end
        check_val("wrap_acc", 32'(bus.accepted), 32'd10);

        // flush during ACK with two entries queued
        do_reset();
        push_word(16'h0A01);
        step(1'b1, 16'h0A02, 1'b0, 1'b0, c);
        step(1'b1, 16'h0A02, 1'b0, 1'b1, c);
        check_val("flush_clr", 32'(c), 32'd0);
        check_val("flush_cnt", 32'(bus.count), 32'd0);
        check_val("flush_acc", 32'(bus.accepted), 32'd2);
        step(1'b1, 16'h0A02, 1'b0, 1'b0, c);
        step(1'b1, 16'h0A02, 1'b0, 1'b0, c);
        check_val("refetch_out", 32'(bus.cmd_out), 32'h0A02);
        check_val("refetch_acc", 32'(bus.accepted), 32'd3);

        // async reset between edges, mid-ACK, count=3
        do_reset();
        push_word(16'h0B01);
        push_word(16'h0B02);
        step(1'b1, 16'h0B03, 1'b0, 1'b0, c);
        bus.cmd_in_rdy = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_val("arst_cnt", 32'(bus.count), 32'd0);
        check_val("arst_rdy", 32'(bus.cmd_out_rdy), 32'd0);
        check_val("arst_full", 32'(bus.full), 32'd0);
        check_val("arst_stall", 32'(bus.stall), 32'd0);
        check_val("arst_clr", 32'(bus.clr_in_rdy), 32'd0);
        check_val("arst_acc", 32'(bus.accepted), 32'd0);
        do_reset();

        // randomized traffic with a UART-like upstream
        up_valid = 1'b0;
        up_data  = '0;
        saw_clr  = 1'b0;
        for (int n = 0; n < 800; n++) begin
            cap_pct = (n < 400) ? 25 : 70;
            if (saw_clr) up_valid = 1'b0;
            if (!up_valid && $urandom_range(99) < 60) begin
                up_valid = 1'b1;
                up_data  = 16'($urandom);
            end
            step(up_valid, up_data, 1'($urandom_range(99) < cap_pct),
                 1'($urandom_range(39) == 0), saw_clr);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/cmd_sched.md
CMD_SCHED -- requirements
Module: cmd_sched

Interface
REQ-001 Parameter DEPTH, default 4, number of 16-bit command entries buffered; legal values 2, 4, 8.
REQ-002 clk  input  1  operational clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cmd_in  input  16  command word from UART_wrapper, valid while cmd_in_rdy=1.
REQ-005 cmd_in_rdy  input  1  level "new command available" from UART_wrapper.
REQ-006 clr_in_rdy  output  1  one-cycle pulse to UART_wrapper clr_cmd_rdy, acknowledging acceptance of cmd_in.
REQ-007 cmd_out  output  16  head-of-queue command word for cmd_proc.
REQ-008 cmd_out_rdy  output  1  head entry valid; drives cmd_proc cmd_rdy.
REQ-009 cap_cmd  input  1  pop strobe from cmd_proc; consumes the head entry.
REQ-010 flush  input  1  synchronous clear of all queued commands, e.g. on collision.
REQ-011 count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
REQ-012 full  output  1  count==DEPTH.
REQ-013 stall  output  1  cmd_in_rdy=1 while full and no same-cycle pop.
REQ-014 accepted  output  8  running count of accepted commands.

Function
REQ-015 Storage: DEPTH x 16 circular buffer with read and write pointers of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-016 Intake FSM states: WAIT, ACK.
- WAIT -> ACK when cmd_in_rdy=1 and (not full, or cap_cmd=1 same cycle); cmd_in written at write pointer that cycle.
- ACK: clr_in_rdy=1 for exactly one cycle; no write; unconditional -> WAIT.
REQ-017 ACK absorbs the one-cycle lag of UART cmd_rdy deassertion; the same UART word is never written twice.
REQ-018 Full with no pop: FSM stays in WAIT, no write, no clr_in_rdy, stall=1; the word is held upstream and never dropped.
REQ-019 cmd_out is the entry at the read pointer, presented combinationally from storage; cmd_out_rdy = (count!=0).
REQ-020 Pop: cap_cmd=1 with count!=0 advances the read pointer; cap_cmd with count==0 is ignored and does not move pointers or count.
REQ-021 Same-cycle push and pop: count unchanged, both pointers advance; legal at full and at count==1.
- At count==0, a push makes the entry visible on cmd_out the next cycle (no fall-through).
REQ-022 Latency: word accepted at edge N sets cmd_out_rdy=1 after edge N when the queue was empty.
REQ-023 flush has priority over push and pop.
- Next cycle: count=0, pointers=0, FSM=WAIT, clr_in_rdy=0.
- flush during ACK aborts ACK with no clr_in_rdy pulse; UART word still pending is accepted later as a fresh command.
REQ-024 accepted increments by 1 per write, wraps 255 -> 0, and is not cleared by flush.
REQ-025 count, full and stall are consistent with pointer state every cycle; count never exceeds DEPTH and never underflows.

Reset
REQ-026 rst=1 asynchronously forces FSM=WAIT, pointers=0, count=0, accepted=0, clr_in_rdy=0, cmd_out_rdy=0, full=0, stall=0.
REQ-027 Storage contents are not reset; cmd_out is don't-care while cmd_out_rdy=0.
REQ-028 Reset mid-ACK suppresses the pending clr_in_rdy pulse.
REQ-029 First write is possible on the first posedge after rst deasserts.

Verification
REQ-030 Single word: cmd_in=16'h00A7 with cmd_in_rdy=1 -> clr_in_rdy one cycle later; next cycle cmd_out=16'h00A7, cmd_out_rdy=1, count=1, accepted=1.
REQ-031 Fill then stall (DEPTH=4): push 16'h0001..16'h0004, hold cmd_in_rdy with 16'h0005 -> full=1, stall=1, no clr_in_rdy; one cap_cmd -> 16'h0005 accepted the same cycle, count stays 4, cmd_out=16'h0002.
REQ-032 Drain in order: four pops after REQ-031 -> cmd_out sequence 16'h0002..16'h0005, then count=0, cmd_out_rdy=0; an extra cap_cmd leaves count=0.
REQ-033 Wrap-around: 10 push/pop pairs with incrementing data -> FIFO order preserved across pointer wrap; accepted=10.
REQ-034 Flush mid-ACK: flush in the ACK cycle with count=2 -> count=0 and no clr_in_rdy next cycle; accepted retains its value.
REQ-035 Async reset: assert rst between edges with count=3 -> outputs reach REQ-026 values immediately, without waiting for a clock edge.
